// File: rtl/tetris_pkg.sv
// Shared Tetris board definitions: geometry, row type and the line-clear state
// encoding exposed to debug/HUD logic.
package tetris_pkg;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;

  typedef logic [BOARD_W-1:0] row_t;

  typedef enum logic [2:0] {
    LC_IDLE = 3'd0,
    LC_READ = 3'd1,
    LC_EVAL = 3'd2,
    LC_FILL = 3'd3,
    LC_DONE = 3'd4
  } line_clear_state_t;

endpackage

// File: rtl/line_clear.sv
// Post-lock board compaction: scans rows bottom-up, drops full rows, shifts the
// rest down, zero-fills the vacated top rows and reports the cleared-row count.
module line_clear #(
  parameter int BOARD_W = tetris_pkg::BOARD_W,
  parameter int BOARD_H = tetris_pkg::BOARD_H
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               start,
  output logic [4:0]         row_rd_addr,
  input  logic [BOARD_W-1:0] row_rd_data,
  output logic               row_wr_en,
  output logic [4:0]         row_wr_addr,
  output logic [BOARD_W-1:0] row_wr_data,
  output logic               busy,
  output logic               done,
  output logic [2:0]         rows_cleared
);
  import tetris_pkg::*;

  localparam logic [2:0] S_IDLE = LC_IDLE;
  localparam logic [2:0] S_READ = LC_READ;
  localparam logic [2:0] S_EVAL = LC_EVAL;
  localparam logic [2:0] S_FILL = LC_FILL;
  localparam logic [2:0] S_DONE = LC_DONE;

  localparam logic [4:0] LAST_ROW = 5'(BOARD_H - 1);

  logic [2:0]         state_r, state_nx;
  logic [4:0]         r_r, r_nx;          // row being read
  logic [4:0]         w_r, w_nx;          // next destination row
  logic [2:0]         n_r, n_nx;          // full rows found so far
  logic [2:0]         k_r, k_nx;          // zero-fill writes issued
  logic [2:0]         n_inc, n_eval;
  logic               row_full;

  logic [4:0]         rd_addr_r, rd_addr_nx;
  logic               wr_en_r, wr_en_nx;
  logic [4:0]         wr_addr_r, wr_addr_nx;
  logic [BOARD_W-1:0] wr_data_r, wr_data_nx;
  logic               busy_r, busy_nx;
  logic               done_r, done_nx;
  logic [2:0]         rows_r, rows_nx;

  // Next-state and next-output decode; every output is computed one cycle
  // ahead so that it can be driven straight from a flop.
  always_comb begin
    state_nx   = state_r;
    r_nx       = r_r;
    w_nx       = w_r;
    n_nx       = n_r;
    k_nx       = k_r;
    rd_addr_nx = rd_addr_r;
    wr_en_nx   = 1'b0;
    wr_addr_nx = wr_addr_r;
    wr_data_nx = wr_data_r;
    done_nx    = 1'b0;
    rows_nx    = rows_r;
    row_full   = &row_rd_data;
    n_inc      = (n_r == 3'd7) ? 3'd7 : (n_r + 3'd1);
    n_eval     = n_r;

    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nx   = S_READ;
          r_nx       = LAST_ROW;
          w_nx       = LAST_ROW;
          n_nx       = 3'd0;
          rd_addr_nx = LAST_ROW;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_READ: begin
        state_nx = S_EVAL;
      end
      S_EVAL: begin
        if (row_full) begin
          n_eval = n_inc;
          n_nx   = n_inc;
        end else begin
          // A row that has not moved is already in place; skip the write.
          if (w_r != r_r) begin
            wr_en_nx   = 1'b1;
            wr_addr_nx = w_r;
            wr_data_nx = row_rd_data;
          end else begin
            wr_en_nx = 1'b0;
          end
          w_nx = w_r - 5'd1;
        end
        if (r_r == 5'd0) begin
          k_nx = 3'd0;
          if (n_eval != 3'd0) begin
            state_nx = S_FILL;
          end else begin
            state_nx = S_DONE;
            done_nx  = 1'b1;
            rows_nx  = n_eval;
          end
        end else begin
          r_nx       = r_r - 5'd1;
          rd_addr_nx = r_r - 5'd1;
          state_nx   = S_READ;
        end
      end
      S_FILL: begin
        wr_en_nx   = 1'b1;
        wr_addr_nx = w_r;
        wr_data_nx = {BOARD_W{1'b0}};
        w_nx       = w_r - 5'd1;
        k_nx       = k_r + 3'd1;
        if ((k_r + 3'd1) == n_r) begin
          state_nx = S_DONE;
          done_nx  = 1'b1;
          rows_nx  = n_r;
        end else begin
          state_nx = S_FILL;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    busy_nx = (state_nx != S_IDLE);
  end

  // State, scan pointers and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r   <= S_IDLE;
      r_r       <= 5'd0;
      w_r       <= 5'd0;
      n_r       <= 3'd0;
      k_r       <= 3'd0;
      rd_addr_r <= 5'd0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= 5'd0;
      wr_data_r <= {BOARD_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      rows_r    <= 3'd0;
    end else begin
      state_r   <= state_nx;
      r_r       <= r_nx;
      w_r       <= w_nx;
      n_r       <= n_nx;
      k_r       <= k_nx;
      rd_addr_r <= rd_addr_nx;
      wr_en_r   <= wr_en_nx;
      wr_addr_r <= wr_addr_nx;
      wr_data_r <= wr_data_nx;
      busy_r    <= busy_nx;
      done_r    <= done_nx;
      rows_r    <= rows_nx;
    end
  end

  assign row_rd_addr  = rd_addr_r;
  assign row_wr_en    = wr_en_r;
  assign row_wr_addr  = wr_addr_r;
  assign row_wr_data  = wr_data_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign rows_cleared = rows_r;

endmodule

// File: tb/tb_line_clear.sv
// Self-checking bench for line_clear: a board RAM model, a list-based compaction
// reference, a per-cycle output checker, directed cases and randomized boards.
module tb_line_clear;

  localparam int W = 10;
  localparam int H = 20;

  logic         clk_in = 1'b0;
  logic         rst_n_in = 1'b0;
  logic         start = 1'b0;
  logic [4:0]   row_rd_addr;
  logic [W-1:0] row_rd_data;
  logic         row_wr_en;
  logic [4:0]   row_wr_addr;
  logic [W-1:0] row_wr_data;
  logic         busy;
  logic         done;
  logic [2:0]   rows_cleared;

  line_clear #(.BOARD_W(W), .BOARD_H(H)) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .start        (start),
    .row_rd_addr  (row_rd_addr),
    .row_rd_data  (row_rd_data),
    .row_wr_en    (row_wr_en),
    .row_wr_addr  (row_wr_addr),
    .row_wr_data  (row_wr_data),
    .busy         (busy),
    .done         (done),
    .rows_cleared (rows_cleared)
  );

  always #5 clk_in = ~clk_in;

  logic [W-1:0] mem [H];
  logic [W-1:0] init_board [H];
  logic         load = 1'b0;
  int           cyc = 0;

  int checks = 0;
  int errors = 0;

  bit         track = 1'b0;
  int         start_cyc = 0;
  int         exp_n = 0;
  int         exp_d = 0;
  logic [2:0] prev_rows = 3'd0;
  int         done_rel = -1;
  int         done_count = 0;
  int         wr_count = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Board RAM with a registered read port.
  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (load) begin
      for (int i = 0; i < H; i++) mem[i] <= init_board[i];
    end else if (row_wr_en && row_wr_addr < 5'(H)) begin
      mem[row_wr_addr] <= row_wr_data;
    end
    row_rd_data <= (row_rd_addr < 5'(H)) ? mem[row_rd_addr] : '0;
  end

  // Per-cycle comparison of all outputs against the expected timeline.
  always @(negedge clk_in) begin
    int rel;
    if (!rst_n_in) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rows_cleared", rows_cleared, 0);
      chk("rst_wr_en", row_wr_en, 0);
      chk("rst_rd_addr", row_rd_addr, 0);
      chk("rst_wr_addr", row_wr_addr, 0);
      chk("rst_wr_data", row_wr_data, 0);
    end else if (track) begin
      rel = cyc - start_cyc;
      chk("busy", busy, (rel >= 1 && rel <= exp_d) ? 1 : 0);
      chk("done", done, (rel == exp_d) ? 1 : 0);
      chk("rows_cleared", rows_cleared, (rel >= exp_d) ? exp_n : int'(prev_rows));
      if (rel == exp_d) prev_rows = 3'(exp_n);
      if (done) begin
        done_count++;
        done_rel = rel;
      end
      if ((rel % 2) == 1 && rel < 2 * H) begin
        chk("rd_addr", row_rd_addr, H - 1 - (rel - 1) / 2);
        if (row_wr_en) chk("rw_same_addr", (row_wr_addr != row_rd_addr) ? 1 : 0, 1);
      end
      if (row_wr_en) begin
        wr_count++;
        chk("wr_window", (rel >= 2 && rel <= exp_d) ? 1 : 0, 1);
      end
    end else begin
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_wr_en", row_wr_en, 0);
      chk("idle_rows_cleared", rows_cleared, prev_rows);
    end
  end

  // Loads init_board, runs one compaction and checks the resulting board.
  task automatic run_op(input bit extra_start, input bit do_reset, output int got_rel);
    logic [W-1:0] exp_b [H];
    int n, k, moved;
    n = 0;
    k = H - 1;
    moved = 0;
    for (int i = H - 1; i >= 0; i--) begin
      if (init_board[i] == {W{1'b1}}) begin
        n++;
      end else begin
        exp_b[k] = init_board[i];
        if (k != i) moved++;
        k--;
      end
    end
    for (int i = k; i >= 0; i--) exp_b[i] = '0;
    exp_n = (n > 7) ? 7 : n;
    exp_d = 2 * H + exp_n + 1;

    @(posedge clk_in); #1 load = 1'b1;
    @(posedge clk_in); #1 load = 1'b0;
    wr_count = 0;
    done_count = 0;
    done_rel = -1;
    start = 1'b1;
    start_cyc = cyc;
    track = 1'b1;
    @(posedge clk_in); #1 start = 1'b0;

    while ((cyc - start_cyc) < exp_d + 2) begin
      if (extra_start && (cyc - start_cyc) == 10) start = 1'b1;
      if (do_reset && (cyc - start_cyc) == 20) begin
        rst_n_in = 1'b0;
        track = 1'b0;
        prev_rows = 3'd0;
        break;
      end
      @(posedge clk_in); #1 start = 1'b0;
    end

    got_rel = done_rel;
    if (do_reset) begin
      #1;
      chk("async_rst_busy", busy, 0);
      chk("async_rst_done", done, 0);
      chk("async_rst_rows", rows_cleared, 0);
      @(posedge clk_in);
      @(posedge clk_in); #1 rst_n_in = 1'b1;
      @(posedge clk_in); #1;
    end else begin
      track = 1'b0;
      chk("done_pulses", done_count, 1);
      chk("write_count", wr_count, moved + exp_n);
      for (int i = 0; i < H; i++) chk($sformatf("row%0d", i), mem[i], exp_b[i]);
    end
  endtask

  task automatic clear_board();
    for (int i = 0; i < H; i++) init_board[i] = '0;
  endtask

  initial begin
    int rel;
    int nf;
    logic [W-1:0] v;

    repeat (3) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    // Empty board: no writes, done at cycle 41.
    clear_board();
    run_op(1'b0, 1'b0, rel);
    chk("empty_done_cycle", rel, 41);
    chk("empty_rows_cleared", rows_cleared, 0);

    // Single bottom row full.
    clear_board();
    init_board[19] = 10'h3FF;
    init_board[18] = 10'h001;
    run_op(1'b0, 1'b0, rel);
    chk("one_done_cycle", rel, 42);
    chk("one_rows_cleared", rows_cleared, 1);
    chk("one_row19", mem[19], 10'h001);
    chk("one_row18", mem[18], 10'h000);
    chk("one_row0", mem[0], 10'h000);

    // Tetris: rows 16-19 full.
    clear_board();
    for (int i = 16; i < 20; i++) init_board[i] = 10'h3FF;
    init_board[15] = 10'h155;
    init_board[0] = 10'h0F3;
    run_op(1'b0, 1'b0, rel);
    chk("tetris_done_cycle", rel, 45);
    chk("tetris_rows_cleared", rows_cleared, 4);
    chk("tetris_row19", mem[19], 10'h155);
    chk("tetris_row4", mem[4], 10'h0F3);
    chk("tetris_row3", mem[3], 10'h000);

    // Non-contiguous full rows.
    clear_board();
    init_board[19] = 10'h3FF;
    init_board[18] = 10'h2AA;
    init_board[17] = 10'h3FF;
    init_board[16] = 10'h0F0;
    run_op(1'b0, 1'b0, rel);
    chk("gap_done_cycle", rel, 43);
    chk("gap_rows_cleared", rows_cleared, 2);
    chk("gap_row19", mem[19], 10'h2AA);
    chk("gap_row18", mem[18], 10'h0F0);
    chk("gap_row17", mem[17], 10'h000);

    // Start pulse mid-operation is ignored.
    clear_board();
    for (int i = 16; i < 20; i++) init_board[i] = 10'h3FF;
    init_board[15] = 10'h155;
    run_op(1'b1, 1'b0, rel);
    chk("busy_start_done_cycle", rel, 45);
    chk("busy_start_rows", rows_cleared, 4);

    // Reset mid-operation, then a fresh run.
    clear_board();
    init_board[19] = 10'h3FF;
    run_op(1'b0, 1'b1, rel);
    chk("post_rst_rows", rows_cleared, 0);
    clear_board();
    init_board[19] = 10'h3FF;
    init_board[18] = 10'h001;
    run_op(1'b0, 1'b0, rel);
    chk("after_rst_done_cycle", rel, 42);
    chk("after_rst_rows", rows_cleared, 1);

    // Randomized boards with up to four full rows.
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < H; i++) begin
        v = W'($urandom);
        if (v == {W{1'b1}}) v[0] = 1'b0;
        init_board[i] = v;
      end
      nf = $urandom_range(0, 4);
      for (int j = 0; j < nf; j++) init_board[$urandom_range(0, H - 1)] = {W{1'b1}};
      run_op(1'b0, 1'b0, rel);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_clear.md
# line_clear

Post-lock board compaction stage. After a piece locks, it scans the playfield bottom-up and removes every full row, shifting the remaining rows down. It then zero-fills the vacated top rows. On completion it reports the number of rows removed with a one-cycle `done` pulse. `done` drives the scoring stage's `start`, and `rows_cleared` drives its `rows_cleared` input.

## Interface
Parameters:
- `BOARD_W`, default 10, cells per row (bit i = column i, 1 = occupied).
- `BOARD_H`, default 20, rows; row 0 = top, row `BOARD_H-1` = bottom.

Ports:
- `clk_in`  in  1  system clock.
- `rst_n_in`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle pulse from lock logic; sampled only in IDLE.
- `row_rd_addr`  out  5  board RAM read address.
- `row_rd_data`  in  BOARD_W  board RAM read data, registered; valid the cycle after the address.
- `row_wr_en`  out  1  board RAM write strobe.
- `row_wr_addr`  out  5  board RAM write address.
- `row_wr_data`  out  BOARD_W  board RAM write data.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `rows_cleared`  out  3  full rows removed in the last operation; held until the next `done`.

## Operation
- States: IDLE, READ, EVAL, FILL, DONE.
- IDLE:
  - On `start`: r = w = `BOARD_H-1`, n = 0, go to READ.
  - Otherwise stay in IDLE.
- READ: drive `row_rd_addr` = r, go to EVAL.
- EVAL: row `row_rd_data` is full iff all `BOARD_W` bits are 1.
  - Full row: n = n+1 (saturating at 7); no write.
  - Not full and w != r: write the row to address w (`row_wr_en`=1, `row_wr_data`=`row_rd_data`), then w = w-1.
  - Not full and w == r: no write; w = w-1.
  - Then: if r == 0, go to FILL when n>0, else DONE. Otherwise r = r-1 and go to READ.
- FILL: write zero at address w, then w = w-1. Go to DONE after n writes, i.e. rows n-1..0.
- DONE: `done`=1, latch `rows_cleared` = n, go to IDLE.
- `start` in any state other than IDLE is ignored; no queuing.
- Reset, including mid-operation:
  - State returns to IDLE and all outputs go to 0 (`rows_cleared`=0).
  - A partially compacted board is acceptable; the board is reinitialised on game reset.
- Non-contiguous full rows (e.g. rows 19 and 17) compact correctly. Rows above shift by the number of full rows below them.

## Timing
- Reset values: `busy`=0, `done`=0, `rows_cleared`=0, `row_wr_en`=0, `row_rd_addr`=0, `row_wr_addr`=0, `row_wr_data`=0.
- All outputs are registered.
- Timeline, with `start` high at cycle 0:
  - READ/EVAL alternate over cycles 1..2·`BOARD_H`.
  - FILL occupies n cycles.
  - `done` is high at cycle 2·`BOARD_H`+n+1. For H=20: cycle 41 with n=0, cycle 45 with n=4.
- `busy` is high from cycle 1 through the `done` cycle inclusive. `start` is accepted again the cycle after `done`.
- `rows_cleared` updates on the same edge that raises `done`.
- At most one `row_wr_en` per cycle; never a write and a read of the same address in the same cycle.

## Structure
- Shared package `tetris_pkg` holds:
  - `BOARD_W`, `BOARD_H` constants;
  - `row_t` typedef (`logic [BOARD_W-1:0]`);
  - the `line_clear_state_t` enum, used by debug/HUD.
- No sub-module; the row-full check is a single reduction-AND inside the block.

## Test plan
- Empty board, `start` → no writes, `done` at cycle 41, `rows_cleared`=0.
- Row 19 full, row 18 = 10'b0000000001 → row 18 written to 19, row 0 zeroed, `rows_cleared`=1, `done` at cycle 42.
- Rows 16–19 full, row 15 = 10'h155 → 10'h155 ends at row 19, rows 0–3 zero, `rows_cleared`=4 (scoring then awards TETRIS), `done` at cycle 45.
- Rows 19 and 17 full, rows 18 = A, 16 = B → A at 19, B at 18, rows 0–1 zero, `rows_cleared`=2.
- `start` pulsed at cycle 10 of a running operation → ignored; single `done`, result unchanged.
- `rst_n_in` low at cycle 20 → immediately `busy`=0, `done`=0, `rows_cleared`=0, state IDLE; a fresh `start` after release completes normally.
